vga_sync_receiver: RTL and testbench
====================================

Name: vga_sync_receiver

Overview:
- Receive-side counterpart of the team's VGA sync generator.
- Samples externally supplied HSYNC/VSYNC/R/G/B (640x480@60, 2 CLOCK_50 cycles per pixel) on CLOCK_50.
- Measures line and frame timing, locks onto a valid stream, and recovers per-pixel coordinates plus the sampled colour.
- Used as an on-board loopback checker for the generator and as the front end of a future capture path.

Parameters:
- H_PERIOD_CLKS, 1600: nominal line period in CLOCK_50 cycles.
- H_PULSE_CLKS, 192: nominal hsync pulse width in cycles.
- H_BACK_CLKS, 288: cycles from hsync leading edge to first active pixel.
- V_LINES, 525: lines per frame.
- V_BACK_LINES, 35: lines from frame start to first active line.
- H_ACTIVE, 640: active pixels per line.
- V_ACTIVE, 480: active lines per frame.
- TOL, 4: allowed ± deviation (cycles) on line period and hsync width.
- LOCK_FRAMES, 2: consecutive clean frames required for lock.

Ports:
- CLOCK_50  input  1  system clock, 50 MHz.
- i_reset  input  1  synchronous reset, active-high.
- i_hsync  input  1  external hsync, active-low, asynchronous.
- i_vsync  input  1  external vsync, active-low, asynchronous.
- i_red  input  1  external red.
- i_grn  input  1  external green.
- i_blu  input  1  external blue.
- o_locked  output  1  stream valid and locked.
- o_de  output  1  current cycle lies in the active region (gated by o_locked).
- o_pix_stb  output  1  one-cycle strobe per active pixel.
- o_x  output  10  pixel column, 0..639.
- o_y  output  10  pixel row, 0..479.
- o_rgb  output  3  {r,g,b} sampled at o_pix_stb.
- o_hperiod  output  12  last measured line period in cycles.
- o_vlines  output  10  last measured lines per frame.
- o_err  output  1  one-cycle pulse on any timing violation.
- o_err_count  output  8  saturating violation count.

Behaviour:

Reset and input conditioning
- One clock (CLOCK_50). Reset is synchronous and active-high (i_reset).
- All outputs reset to 0; the FSM resets to SEARCH.
- All five inputs pass through a 2-flop synchronizer.
- Edge detect operates on the synchronized signals:
  - hsync leading edge = 1→0; trailing edge = 0→1.
  - vsync "active" = synchronized vsync == 0.

Line timing
- h_cnt (12 bit) is cleared to 0 on each hsync leading edge, otherwise increments, saturating at 4095.
- On a leading edge:
  - o_hperiod ← h_cnt+1.
  - Line error if |h_cnt+1 − H_PERIOD_CLKS| > TOL.
- On a trailing edge: pulse error if |h_cnt+1 − H_PULSE_CLKS| > TOL.

Line counting and frame start
- line_idx (10 bit) updates on each hsync leading edge.
- Frame start = vsync active at this leading edge but not at the previous one.
- At frame start:
  - o_vlines ← line_idx+1; frame error if ≠ V_LINES.
  - line_idx ← 0.
- Otherwise line_idx increments, saturating at 1023.

Timeout
- If h_cnt reaches 2*H_PERIOD_CLKS: timeout error, FSM → SEARCH.

FSM
- SEARCH: wait for a frame start → ACQUIRE, good=0. Errors are ignored in this state.
- ACQUIRE: each frame start:
  - Frame with no error since the previous start: good+1. When good == LOCK_FRAMES → LOCKED.
  - Any error in the frame: good=0, stay in ACQUIRE.
- LOCKED:
  - Any error → ACQUIRE, good=0, o_locked=0 on the next cycle.
  - Timeout → SEARCH.
- o_locked = 1 only in LOCKED.

Error reporting
- o_err pulses for one cycle per violation, in ACQUIRE and LOCKED only.
- o_err_count increments per violation and saturates at 255.
- Two violations in the same cycle count as one.

Pixel recovery (registered)
- hx = h_cnt − H_BACK_CLKS; vy = line_idx − V_BACK_LINES.
- Active region: o_de = o_locked && 0 ≤ hx < 2*H_ACTIVE && 0 ≤ vy < V_ACTIVE.
- o_pix_stb = o_de && hx odd.
- On o_pix_stb:
  - o_x = hx>>1, o_y = vy.
  - o_rgb = synchronized {r,g,b}.
- o_x, o_y, o_rgb hold their values between strobes.

Latency and mid-operation reset
- Input-to-o_rgb latency: 3 cycles (2 synchronizer + 1 register).
- Reset mid-frame: all counters cleared, FSM → SEARCH; lock requires a fresh frame start plus LOCK_FRAMES clean frames.

Test Plan:
- Reset released, ideal 640x480 stream from frame start:
  - o_locked rises just after the 3rd frame start (first start + 2 clean frames).
  - o_hperiod = 1600, o_vlines = 525.
- Locked stream, colour checks:
  - R=1, G=0, B=1 only during pixel x=100, y=200 → exactly one o_pix_stb with o_x=100, o_y=200, o_rgb=3'b101.
  - First o_pix_stb of each frame has o_x=0, o_y=0.
  - Exactly 640×480 strobes per frame.
- Line period tolerance while locked:
  - One line at 1604 cycles → no error.
  - One line at 1605 cycles → o_err pulse, o_err_count=1, o_locked=0; relock after 2 clean frames.
- Frame of 524 lines while locked → frame error at the following frame start, o_vlines=524, o_locked drops.
- hsync held high while locked → 3200 cycles after the last leading edge, FSM in SEARCH, o_locked=0, o_de=0; no further o_err pulses while in SEARCH.
- i_reset asserted mid-frame for 1 cycle while locked → next cycle all outputs 0; relock only after a new frame start plus 2 clean frames; o_err_count=0 after reset.

Source files
------------

// File: rtl/vga_sync_receiver.sv
// vga_sync_receiver: locks onto an external VGA sync stream and recovers pixel coordinates and colour
module vga_sync_receiver #(
    parameter int H_PERIOD_CLKS = 1600,
    parameter int H_PULSE_CLKS  = 192,
    parameter int H_BACK_CLKS   = 288,
    parameter int V_LINES       = 525,
    parameter int V_BACK_LINES  = 35,
    parameter int H_ACTIVE      = 640,
    parameter int V_ACTIVE      = 480,
    parameter int TOL           = 4,
    parameter int LOCK_FRAMES   = 2
) (
    input  logic        CLOCK_50,
    input  logic        i_reset,
    input  logic        i_hsync,
    input  logic        i_vsync,
    input  logic        i_red,
    input  logic        i_grn,
    input  logic        i_blu,
    output logic        o_locked,
    output logic        o_de,
    output logic        o_pix_stb,
    output logic [9:0]  o_x,
    output logic [9:0]  o_y,
    output logic [2:0]  o_rgb,
    output logic [11:0] o_hperiod,
    output logic [9:0]  o_vlines,
    output logic        o_err,
    output logic [7:0]  o_err_count
);
    localparam logic [1:0] SEARCH = 2'd0, ACQUIRE = 2'd1, LOCKED = 2'd2;
    localparam logic [12:0] P_HI = 13'(H_PERIOD_CLKS + TOL), P_LO = 13'(H_PERIOD_CLKS - TOL);
    localparam logic [12:0] W_HI = 13'(H_PULSE_CLKS + TOL), W_LO = 13'(H_PULSE_CLKS - TOL);
    localparam logic [11:0] H_TMO = 12'(2 * H_PERIOD_CLKS), H_BACK = 12'(H_BACK_CLKS);
    localparam logic [11:0] H_END = 12'(H_BACK_CLKS + 2 * H_ACTIVE);
    localparam logic [9:0] V_BACK = 10'(V_BACK_LINES), V_END = 10'(V_BACK_LINES + V_ACTIVE);
    localparam logic [10:0] V_NOM = 11'(V_LINES);
    localparam logic [7:0] GOOD_MAX = 8'(LOCK_FRAMES);

    logic [4:0] sync1_q, sync2_q;
    logic hs_prev_q, vs_lead_q, err_seen_q, err_seen_d;
    logic [11:0] h_cnt_q, h_cnt_d;
    logic [9:0] line_idx_q, line_idx_d, vy;
    logic [10:0] hx;
    logic [1:0] state_q, state_d;
    logic [7:0] good_q, good_d;
    logic [12:0] h1;
    logic [10:0] v1;
    logic lead, trail, frame_start, timeout, any_err, err_ev, bad, de;

    always_comb begin
        lead = hs_prev_q && !sync2_q[4];
        trail = !hs_prev_q && sync2_q[4];
        frame_start = lead && !sync2_q[3] && !vs_lead_q;
        h1 = {1'b0, h_cnt_q} + 13'd1;
        v1 = {1'b0, line_idx_q} + 11'd1;
        timeout = h_cnt_q == H_TMO;
        any_err = timeout || (lead && (h1 > P_HI || h1 < P_LO)) ||
                  (trail && (h1 > W_HI || h1 < W_LO)) || (frame_start && v1 != V_NOM);
        err_ev = any_err && state_q != SEARCH;
        // bad covers every reported violation since the previous frame start, including this cycle's
        bad = err_seen_q || err_ev;
        err_seen_d = frame_start ? 1'b0 : bad;
        h_cnt_d = lead ? 12'd0 : h_cnt_q + {11'd0, h_cnt_q != 12'hfff};
        line_idx_d = frame_start ? 10'd0 : lead ? line_idx_q + {9'd0, line_idx_q != 10'h3ff} : line_idx_q;
        state_d = timeout ? SEARCH :
                  state_q == SEARCH ? (frame_start ? ACQUIRE : SEARCH) :
                  state_q == ACQUIRE ? ((frame_start && !bad && good_q + 8'd1 == GOOD_MAX) ? LOCKED : ACQUIRE) :
                  (err_ev ? ACQUIRE : LOCKED);
        good_d = (state_q == SEARCH || (state_q == LOCKED && err_ev)) ? 8'd0 :
                 (state_q == ACQUIRE && frame_start) ? (bad ? 8'd0 : good_q + 8'd1) : good_q;
        hx = 11'(h_cnt_q - H_BACK);
        vy = line_idx_q - V_BACK;
        de = state_q == LOCKED && h_cnt_q >= H_BACK && h_cnt_q < H_END &&
             line_idx_q >= V_BACK && line_idx_q < V_END;
    end

    always_ff @(posedge CLOCK_50) begin
        if (i_reset) begin
            sync1_q <= 5'b11000;
            sync2_q <= 5'b11000;
            hs_prev_q <= 1'b1;
            vs_lead_q <= 1'b0;
            err_seen_q <= 1'b0;
            h_cnt_q <= '0;
            line_idx_q <= '0;
            state_q <= SEARCH;
            good_q <= '0;
            o_hperiod <= '0;
            o_vlines <= '0;
            o_de <= 1'b0;
            o_pix_stb <= 1'b0;
            o_x <= '0;
            o_y <= '0;
            o_rgb <= '0;
            o_err <= 1'b0;
            o_err_count <= '0;
        end else begin
            sync1_q <= {i_hsync, i_vsync, i_red, i_grn, i_blu};
            sync2_q <= sync1_q;
            hs_prev_q <= sync2_q[4];
            if (lead) vs_lead_q <= !sync2_q[3];
            err_seen_q <= err_seen_d;
            h_cnt_q <= h_cnt_d;
            line_idx_q <= line_idx_d;
            state_q <= state_d;
            good_q <= good_d;
            if (lead) o_hperiod <= h1[12] ? 12'hfff : h1[11:0];
            if (frame_start) o_vlines <= v1[10] ? 10'h3ff : v1[9:0];
            o_de <= de;
            o_pix_stb <= de && hx[0];
            if (de && hx[0]) begin
                o_x <= hx[10:1];
                o_y <= vy;
                o_rgb <= sync2_q[2:0];
            end
            o_err <= err_ev;
            if (err_ev && o_err_count != 8'hff) o_err_count <= o_err_count + 8'd1;
        end
    end

    assign o_locked = state_q == LOCKED;
endmodule

// File: tb/tb_vga_sync_receiver.sv
// tb_vga_sync_receiver: directed checks of lock, pixel recovery and error handling on scaled-down timing
module tb_vga_sync_receiver;
    localparam int HP = 40, HW = 6, HB = 10, VL = 12, VB = 2, HA = 8, VA = 6, TOL = 2, VP = 2;
    logic clk = 0, rst = 0, hs = 1, vs = 1;
    logic [2:0] rgb = 3'b000;
    logic locked, de, stb, err;
    logic [9:0] x, y, vlines;
    logic [2:0] rgb_o;
    logic [11:0] hperiod;
    logic [7:0] err_count;
    int checks = 0, errors = 0;
    int stb_cnt = 0, hit_cnt = 0, err_pulses = 0;
    logic first_pend = 0;
    logic [9:0] fx = 0, fy = 0, hit_x = 0, hit_y = 0;
    logic [2:0] hit_rgb = 0;

    always #5 clk = ~clk;

    vga_sync_receiver #(
        .H_PERIOD_CLKS(HP), .H_PULSE_CLKS(HW), .H_BACK_CLKS(HB), .V_LINES(VL), .V_BACK_LINES(VB),
        .H_ACTIVE(HA), .V_ACTIVE(VA), .TOL(TOL), .LOCK_FRAMES(2)
    ) dut (
        .CLOCK_50(clk), .i_reset(rst), .i_hsync(hs), .i_vsync(vs),
        .i_red(rgb[2]), .i_grn(rgb[1]), .i_blu(rgb[0]),
        .o_locked(locked), .o_de(de), .o_pix_stb(stb), .o_x(x), .o_y(y), .o_rgb(rgb_o),
        .o_hperiod(hperiod), .o_vlines(vlines), .o_err(err), .o_err_count(err_count)
    );

    always @(negedge clk) begin
        if (err) err_pulses++;
        if (stb) begin
            stb_cnt++;
            if (first_pend) begin
                fx = x;
                fy = y;
                first_pend = 0;
            end
            if (rgb_o != 3'b000) begin
                hit_cnt++;
                hit_x = x;
                hit_y = y;
                hit_rgb = rgb_o;
            end
        end
    end

    task automatic tick(input logic h, input logic v, input logic [2:0] c);
        @(negedge clk);
        hs = h;
        vs = v;
        rgb = c;
    endtask

    // colour window straddles the receiver's sample point for pixel cx without reaching its neighbours' samples
    task automatic line(input int len, input logic v, input int cx);
        for (int p = 0; p < len; p++)
            tick(p >= HW, v, (cx >= 0 && p > HB + 2 * cx && p <= HB + 2 * cx + 3) ? 3'b101 : 3'b000);
    endtask

    task automatic lines(input int from, input int to, input int long_ln, input int long_len, input int cx, input int cy);
        for (int l = from; l < to; l++)
            line(l == long_ln ? long_len : HP, l >= VP, l == cy + VB ? cx : -1);
    endtask

    task automatic test_reset();
        rst = 1;
        repeat (3) tick(1'b1, 1'b1, 3'b000);
        rst = 0;
        checks++;
        if ({locked, de, stb, err, x, y, rgb_o, hperiod, vlines, err_count} !== '0) begin
            errors++;
            $display("FAIL reset_outputs locked=%0b de=%0b hperiod=%0d vlines=%0d err_count=%0d expected all 0",
                     locked, de, hperiod, vlines, err_count);
        end
    endtask

    task automatic test_acquire();
        lines(0, VL, -1, 0, -1, -1);
        lines(0, VL, -1, 0, -1, -1);
        checks++;
        if (locked !== 1'b0) begin errors++; $display("FAIL acquire_early locked=%0b expected 0", locked); end
        lines(0, 1, -1, 0, -1, -1);
        checks++;
        if (locked !== 1'b1) begin errors++; $display("FAIL acquire_lock locked=%0b expected 1", locked); end
        checks++;
        if (hperiod !== 12'(HP)) begin errors++; $display("FAIL hperiod got %0d expected %0d", hperiod, HP); end
        checks++;
        if (vlines !== 10'(VL)) begin errors++; $display("FAIL vlines got %0d expected %0d", vlines, VL); end
        lines(1, VL, -1, 0, -1, -1);
    endtask

    task automatic test_pixels();
        stb_cnt = 0;
        first_pend = 1;
        lines(0, VL, -1, 0, -1, -1);
        checks++;
        if (stb_cnt != HA * VA) begin errors++; $display("FAIL strobe_count got %0d expected %0d", stb_cnt, HA * VA); end
        checks++;
        if (fx !== 10'd0 || fy !== 10'd0) begin errors++; $display("FAIL first_pixel got x=%0d y=%0d expected 0,0", fx, fy); end
    endtask

    task automatic test_colour();
        hit_cnt = 0;
        lines(0, VL, -1, 0, 3, 4);
        checks++;
        if (hit_cnt != 1) begin errors++; $display("FAIL colour_hits got %0d expected 1", hit_cnt); end
        checks++;
        if (hit_x !== 10'd3 || hit_y !== 10'd4 || hit_rgb !== 3'b101) begin
            errors++;
            $display("FAIL colour_pixel got x=%0d y=%0d rgb=%b expected x=3 y=4 rgb=101", hit_x, hit_y, hit_rgb);
        end
    endtask

    task automatic test_tolerance();
        err_pulses = 0;
        lines(0, VL, 9, HP + TOL, -1, -1);
        checks++;
        if (err_pulses != 0 || locked !== 1'b1) begin
            errors++;
            $display("FAIL tol_edge err_pulses=%0d locked=%0b expected 0 and 1", err_pulses, locked);
        end
        lines(0, VL, 5, HP + TOL + 1, -1, -1);
        checks++;
        if (err_pulses != 1 || err_count !== 8'd1 || locked !== 1'b0) begin
            errors++;
            $display("FAIL tol_over err_pulses=%0d err_count=%0d locked=%0b expected 1 1 0", err_pulses, err_count, locked);
        end
        lines(0, VL, -1, 0, -1, -1);
        lines(0, VL, -1, 0, -1, -1);
        checks++;
        if (locked !== 1'b0) begin errors++; $display("FAIL tol_relock_early locked=%0b expected 0", locked); end
        lines(0, 1, -1, 0, -1, -1);
        checks++;
        if (locked !== 1'b1) begin errors++; $display("FAIL tol_relock locked=%0b expected 1", locked); end
        lines(1, VL, -1, 0, -1, -1);
    endtask

    task automatic test_short_frame();
        err_pulses = 0;
        lines(0, VL - 1, -1, 0, -1, -1);
        lines(0, 1, -1, 0, -1, -1);
        checks++;
        if (vlines !== 10'(VL - 1) || err_pulses != 1 || err_count !== 8'd2 || locked !== 1'b0) begin
            errors++;
            $display("FAIL short_frame vlines=%0d err_pulses=%0d err_count=%0d locked=%0b expected %0d 1 2 0",
                     vlines, err_pulses, err_count, locked, VL - 1);
        end
        lines(1, VL, -1, 0, -1, -1);
        lines(0, VL, -1, 0, -1, -1);
        lines(0, 1, -1, 0, -1, -1);
        checks++;
        if (locked !== 1'b1 || vlines !== 10'(VL)) begin
            errors++;
            $display("FAIL short_relock locked=%0b vlines=%0d expected 1 %0d", locked, vlines, VL);
        end
        lines(1, VL, -1, 0, -1, -1);
    endtask

    task automatic test_timeout();
        lines(0, VL, -1, 0, -1, -1);
        err_pulses = 0;
        repeat (35) tick(1'b1, 1'b1, 3'b000);
        checks++;
        if (locked !== 1'b1) begin errors++; $display("FAIL timeout_early locked=%0b expected 1", locked); end
        repeat (15) tick(1'b1, 1'b1, 3'b000);
        checks++;
        if (locked !== 1'b0 || de !== 1'b0 || err_pulses != 1 || err_count !== 8'd3) begin
            errors++;
            $display("FAIL timeout locked=%0b de=%0b err_pulses=%0d err_count=%0d expected 0 0 1 3",
                     locked, de, err_pulses, err_count);
        end
        repeat (300) tick(1'b1, 1'b1, 3'b000);
        checks++;
        if (err_pulses != 1) begin errors++; $display("FAIL search_quiet err_pulses=%0d expected 1", err_pulses); end
    endtask

    task automatic test_mid_reset();
        lines(0, VL, -1, 0, -1, -1);
        lines(0, VL, -1, 0, -1, -1);
        lines(0, 5, -1, 0, -1, -1);
        checks++;
        if (locked !== 1'b1) begin errors++; $display("FAIL pre_reset_lock locked=%0b expected 1", locked); end
        for (int p = 0; p < HP; p++) begin
            tick(p >= HW, 1'b1, 3'b000);
            rst = (p == 20);
            if (p == 21) begin
                checks++;
                if ({locked, de, stb, err, x, y, rgb_o, hperiod, vlines, err_count} !== '0) begin
                    errors++;
                    $display("FAIL mid_reset locked=%0b de=%0b x=%0d y=%0d hperiod=%0d vlines=%0d err_count=%0d expected all 0",
                             locked, de, x, y, hperiod, vlines, err_count);
                end
            end
        end
        lines(6, VL, -1, 0, -1, -1);
        lines(0, VL, -1, 0, -1, -1);
        lines(0, VL, -1, 0, -1, -1);
        checks++;
        if (locked !== 1'b0) begin errors++; $display("FAIL reset_relock_early locked=%0b expected 0", locked); end
        lines(0, 1, -1, 0, -1, -1);
        checks++;
        if (locked !== 1'b1 || err_count !== 8'd0) begin
            errors++;
            $display("FAIL reset_relock locked=%0b err_count=%0d expected 1 0", locked, err_count);
        end
        lines(1, VL, -1, 0, -1, -1);
    endtask

    initial begin
        test_reset();
        test_acquire();
        test_pixels();
        test_colour();
        test_tolerance();
        test_short_frame();
        test_timeout();
        test_mid_reset();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
